apb_slave_mem: RTL and testbench

APB3 completer that terminates the transfers issued by the team's APB requester (the `apb` block). It holds a word-addressed register memory and inserts a programmable number of wait states. It flags illegal accesses with pslverr and keeps a saturating count of errored transfers. It sits on the requester's pselx/penable/pwrite/paddr/pwdata bus, and the env uses it as the default target in block- and top-level benches.

---
 rtl/apb_slave_mem.sv | 129 ++++++++++++
 tb/tb_apb_slave_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory, with a programmable
// number of wait states, pslverr on illegal addresses and a saturating error counter.
module apb_slave_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int WAIT_W     = 4,
  parameter int ERRCNT_W   = 8
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [WAIT_W-1:0]     wait_cfg_i,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic [ERRCNT_W-1:0]   err_cnt_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  // Handshake: a transfer starts on a setup cycle (pselx=1, penable=0) seen in
  // IDLE and ends on the single cycle where pready=1; pselx=0 before that aborts.
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_write;
  logic                  r_err;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [ERRCNT_W-1:0]   r_err_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_setup;
  logic                  w_in_err;
  logic [IDX_W-1:0]      w_in_idx;
  logic                  w_raise;
  logic                  w_done;
  logic                  w_sel_err;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_sel_rd;

  assign w_setup  = pselx && !penable;
  assign w_in_err = (paddr[1:0] != 2'b00) || (32'(paddr[ADDR_WIDTH-1:2]) >= DEPTH);
  assign w_in_idx = paddr[IDX_W+1:2];

  // A zero-wait transfer raises pready on the setup edge, before anything is
  // latched, so the completion source comes straight from the bus in IDLE.
  assign w_sel_err = (r_state == S_IDLE) ? w_in_err : r_err;
  assign w_sel_idx = (r_state == S_IDLE) ? w_in_idx : r_idx;
  assign w_sel_rd  = (r_state == S_IDLE) ? !pwrite  : !r_write;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_raise     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_state_nxt = S_ACCESS;
          w_raise     = (wait_cfg_i == '0);
        end
      end
      S_ACCESS: begin
        if (r_pready) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else if (!pselx) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_raise = (r_wait == WAIT_W'(1));
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_wait    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_pready  <= w_raise;
      r_pslverr <= w_raise && w_sel_err;
      if (w_raise && w_sel_rd) r_prdata <= w_sel_err ? '0 : r_mem[w_sel_idx];

      if (r_state == S_IDLE && w_setup) begin
        r_write <= pwrite;
        r_err   <= w_in_err;
        r_idx   <= w_in_idx;
        r_wdata <= pwdata;
        r_wait  <= wait_cfg_i;
      end else if (r_state == S_ACCESS && !r_pready && pselx && r_wait != '0) begin
        r_wait <= r_wait - 1'b1;
      end

      if (w_done && r_write && !r_err) r_mem[r_idx] <= r_wdata;
      if (w_done && r_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign pready    = r_pready;
  assign pslverr   = r_pslverr;
  assign prdata    = r_prdata;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem (ERRCNT_W=2 so counter saturation is reachable):
// wait-state timing, read/write, address errors, back-to-back, abort and reset.
module tb_apb_slave_mem;

  logic        pclk;
  logic        preset_n;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  wait_cfg_i;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;
  logic [1:0]  err_cnt_o;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;
  logic        er;
  int          nc;
  logic        seen;

  apb_slave_mem #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_W(4), .ERRCNT_W(2)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .wait_cfg_i(wait_cfg_i),
    .pready(pready), .pslverr(pslverr), .prdata(prdata), .err_cnt_o(err_cnt_o)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the completion edge so a
  // following call issues its setup with no idle cycle. Access-phase bus values
  // are scrambled to show the latched copies are used.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [3:0] wc, input int abort_at,
                          output logic [31:0] r_data, output logic r_err, output int n_cyc);
    int  limit;
    bit  done;
    pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; wait_cfg_i = wc;
    @(negedge pclk);
    check("setup_pready", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1; pwrite = ~wr; paddr = addr ^ 8'h04; pwdata = ~wd; wait_cfg_i = ~wc;
    n_cyc = 0; r_data = '0; r_err = 1'b0; done = 1'b0;
    limit = (abort_at != 0) ? abort_at + 6 : 40;
    for (int c = 1; c <= limit && !done; c++) begin
      if (abort_at != 0 && c == abort_at) begin
        pselx = 1'b0; penable = 1'b0;
      end
      @(negedge pclk);
      if (pready) begin
        done = 1'b1; n_cyc = c; r_data = prdata; r_err = pslverr;
      end
      @(posedge pclk); #1;
    end
    pselx = 1'b0; penable = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [3:0] wc, input logic exp_err);
    apb_xfer(wr, addr, wd, wc, 0, rd, er, nc);
    check({tag, "_lat"}, 32'(nc), 32'(wc) + 32'd1);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    if (!wr) check({tag, "_rdata"}, rd, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    pselx = 1'b0; penable = 1'b0;
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    preset_n = 1'b0; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; wait_cfg_i = '0;
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;
    @(negedge pclk);
    check("rst_pready",  32'(pready),    32'd0);
    check("rst_pslverr", 32'(pslverr),   32'd0);
    check("rst_prdata",  prdata,         32'd0);
    check("rst_errcnt",  32'(err_cnt_o), 32'd0);
    @(posedge pclk); #1;

    // stray penable without setup does nothing
    penable = 1'b1;
    @(negedge pclk);
    check("stray_penable", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    idle(1);

    exp_q.push_back(32'h0);
    run_xfer("rd04_w0", 1'b0, 8'h04, 32'h0, 4'd0, 1'b0);
    idle(1);

    run_xfer("wr08_w3", 1'b1, 8'h08, 32'hDEADBEEF, 4'd3, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    run_xfer("rd08_raw", 1'b0, 8'h08, 32'h0, 4'd0, 1'b0);
    idle(2);

    // out-of-range write: index 16 must not alias onto word 0
    run_xfer("wr40_err", 1'b1, 8'h40, 32'h12345678, 4'd1, 1'b1);
    check("errcnt_1", 32'(err_cnt_o), 32'd1);
    exp_q.push_back(32'h0);
    run_xfer("rd00_unchg", 1'b0, 8'h00, 32'h0, 4'd0, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    run_xfer("rd08_again", 1'b0, 8'h08, 32'h0, 4'd1, 1'b0);
    exp_q.push_back(32'h0);
    run_xfer("rd06_misal", 1'b0, 8'h06, 32'h0, 4'd2, 1'b1);
    check("errcnt_2", 32'(err_cnt_o), 32'd2);
    idle(1);

    run_xfer("b2b_wr00", 1'b1, 8'h00, 32'h11, 4'd0, 1'b0);
    run_xfer("b2b_wr04", 1'b1, 8'h04, 32'h22, 4'd0, 1'b0);
    exp_q.push_back(32'h11);
    run_xfer("b2b_rd00", 1'b0, 8'h00, 32'h0, 4'd0, 1'b0);
    exp_q.push_back(32'h22);
    run_xfer("b2b_rd04", 1'b0, 8'h04, 32'h0, 4'd0, 1'b0);
    run_xfer("wr0c_w1", 1'b1, 8'h0C, 32'h33, 4'd1, 1'b0);
    @(negedge pclk);
    check("prdata_hold", prdata, 32'h22);
    @(posedge pclk); #1;

    // abort in the 2nd wait cycle
    apb_xfer(1'b1, 8'h0C, 32'hCAFEF00D, 4'd5, 2, rd, er, nc);
    check("abort_no_pready", 32'(nc), 32'd0);
    check("abort_errcnt", 32'(err_cnt_o), 32'd2);
    idle(1);
    exp_q.push_back(32'h33);
    run_xfer("rd0c_abort", 1'b0, 8'h0C, 32'h0, 4'd0, 1'b0);

    // highest legal word
    run_xfer("wr3c_edge", 1'b1, 8'h3C, 32'hA5A5A5A5, 4'd1, 1'b0);
    exp_q.push_back(32'hA5A5A5A5);
    run_xfer("rd3c_edge", 1'b0, 8'h3C, 32'h0, 4'd0, 1'b0);

    // saturation of the 2-bit counter
    run_xfer("sat_wr41", 1'b1, 8'h41, 32'h1, 4'd0, 1'b1);
    check("errcnt_3", 32'(err_cnt_o), 32'd3);
    exp_q.push_back(32'h0);
    run_xfer("sat_rdfc", 1'b0, 8'hFC, 32'h0, 4'd1, 1'b1);
    check("errcnt_sat_a", 32'(err_cnt_o), 32'd3);
    exp_q.push_back(32'h0);
    run_xfer("sat_rd43", 1'b0, 8'h43, 32'h0, 4'd0, 1'b1);
    check("errcnt_sat_b", 32'(err_cnt_o), 32'd3);
    idle(1);

    // reset during the pready cycle of a write
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h77; wait_cfg_i = 4'd2;
    @(posedge pclk); #1;
    penable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge pclk);
      seen = pready;
    end
    check("rst_mid_pready_seen", 32'(seen), 32'd1);
    #1 preset_n = 1'b0;
    #1 check("rst_mid_pready_low", 32'(pready), 32'd0);
    pselx = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    #1 preset_n = 1'b1;
    idle(1);
    check("rst_mid_errcnt", 32'(err_cnt_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'h0);
      run_xfer("rst_mem", 1'b0, 8'(i * 4), 32'h0, 4'd0, 1'b0);
    end

    idle(2);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
